// File: rtl/ft245_tx_fifo_hsk_pkg.sv
// rtl/ft245_tx_fifo_hsk_pkg.sv - shared FT245 TX FIFO definitions: FSM encodings and default depth
package ft245_tx_fifo_hsk_pkg;

    localparam int FT245_DEPTH_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/ft245_tx_fifo_hsk_mem.sv
// rtl/ft245_tx_fifo_hsk_mem.sv - byte storage for the FT245 TX FIFO: one write port, async read port
module ft245_tx_fifo_mem #(
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   in_clk,
    input  logic                   wr_en,
    input  logic [DEPTH_WIDTH-1:0] wr_addr,
    input  logic [7:0]             wr_data,
    input  logic [DEPTH_WIDTH-1:0] rd_addr,
    output logic [7:0]             rd_data
);

    logic [7:0] mem [1 << DEPTH_WIDTH];

    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ft245_tx_fifo_hsk.sv
// rtl/ft245_tx_fifo_hsk.sv - TX FIFO feeding an FT245 controller over a four-phase req/ack handshake
// Optional sticky drop flag enabled by defining FT245_TX_FIFO_OVERFLOW_FLAG_EN.
module ft245_tx_fifo_hsk
    import ft245_tx_fifo_hsk_pkg::*;
#(
    parameter int DEPTH_WIDTH = FT245_DEPTH_WIDTH_DEF
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_wr_en,
    input  logic [7:0]           in_wr_data,
    output logic                 out_full,
    output logic                 out_empty,
    output logic [DEPTH_WIDTH:0] out_level,
    output logic                 out_tx_hsk_req,
    input  logic                 in_tx_hsk_ack,
    output logic [7:0]           out_tx_data,
    output logic                 out_overflow
);

    localparam logic [DEPTH_WIDTH:0] DEPTH_LVL = {1'b1, {DEPTH_WIDTH{1'b0}}};

    tx_state_e              state, state_next;
    logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_WIDTH:0]   level;
    logic                   req_q, req_next;
    logic [7:0]             data_q;
    logic [7:0]             rd_data;
    logic                   wr_accept;
    logic                   pop;

    assign out_full       = (level == DEPTH_LVL);
    assign out_empty      = (level == '0);
    assign out_level      = level;
    assign out_tx_hsk_req = req_q;
    assign out_tx_data    = data_q;

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign wr_accept = in_wr_en && !out_full;

    ft245_tx_fifo_mem #(
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_mem (
        .in_clk  (in_clk),
        .wr_en   (wr_accept && !in_rst),
        .wr_addr (wr_ptr),
        .wr_data (in_wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next = state;
        req_next   = req_q;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!out_empty) begin
                    pop        = 1'b1;
                    req_next   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (in_tx_hsk_ack) begin
                    req_next   = 1'b0;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!in_tx_hsk_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            req_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            state <= state_next;
            req_q <= req_next;
            if (pop) begin
                data_q <= rd_data;
                rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            end
            case ({wr_accept, pop})
                2'b10:   level <= level + (DEPTH_WIDTH+1)'(1);
                2'b01:   level <= level - (DEPTH_WIDTH+1)'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef FT245_TX_FIFO_OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            overflow_q <= 1'b0;
        end else if (in_wr_en && out_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_overflow = overflow_q;
`else
    assign out_overflow = 1'b0;
`endif

endmodule
